// File: rtl/line_xfer_ctrl.sv
// line_xfer_ctrl
//   Moves one cache line between the cache data array and a word-addressed
//   memory. An optional write-back of the victim line precedes the fill.
//   Each line is LINE_WORDS = 2**OFFSET_BITS words, one word per cycle.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req, wb             start a transfer (taken only while ready), write-back qualifier
//   wb_base, fill_base  victim / fill line addresses (offset bits ignored)
//   ready, done         idle indication, one-cycle completion pulse
//   cache_word          word offset into the cache line
//   cache_rdata         victim word at cache_word (combinational)
//   cache_we, cache_wdata  fill word write into the cache line
//   mem_sel, mem_rd, mem_wr, mem_addr, mem_wdata, mem_rdata  memory port
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | ready for a request; captures line bases on acceptance
// WBACK  | writes victim word cnt from cache to memory
// FILL   | reads memory word cnt and writes it into the cache
// DONE   | single-cycle completion pulse, then back to IDLE
module line_xfer_ctrl #(
    parameter int ADR_WIDTH   = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int OFFSET_BITS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   wb,
    input  logic [ADR_WIDTH-1:0]   wb_base,
    input  logic [ADR_WIDTH-1:0]   fill_base,
    output logic                   ready,
    output logic                   done,
    output logic [OFFSET_BITS-1:0] cache_word,
    input  logic [DATA_WIDTH-1:0]  cache_rdata,
    output logic                   cache_we,
    output logic [DATA_WIDTH-1:0]  cache_wdata,
    output logic                   mem_sel,
    output logic                   mem_rd,
    output logic                   mem_wr,
    output logic [ADR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic [DATA_WIDTH-1:0]  mem_rdata
);

    localparam int LINE_WORDS = 2**OFFSET_BITS;
    localparam logic [OFFSET_BITS-1:0] CNT_LAST  = OFFSET_BITS'(LINE_WORDS - 1);
    localparam logic [ADR_WIDTH-1:0]   LINE_MASK = ~ADR_WIDTH'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WBACK = 2'd1,
        S_FILL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [OFFSET_BITS-1:0] cnt;
    logic [ADR_WIDTH-1:0]   wb_base_r;
    logic [ADR_WIDTH-1:0]   fill_base_r;
    logic                   last_word;
    logic [ADR_WIDTH-1:0]   word_off;

    assign last_word = (cnt == CNT_LAST);
    // Bases have their offset bits cleared, so OR-ing the offset in can never
    // carry into the line bits.
    assign word_off  = ADR_WIDTH'(cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            wb_base_r   <= '0;
            fill_base_r <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        wb_base_r   <= wb_base & LINE_MASK;
                        fill_base_r <= fill_base & LINE_MASK;
                        cnt         <= '0;
                    end
                end
                // Counter wraps naturally to 0 after the last word, which is
                // exactly the start offset needed by the following phase.
                S_WBACK, S_FILL: cnt <= cnt + OFFSET_BITS'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (req) state_nxt = wb ? S_WBACK : S_FILL;
            S_WBACK: if (last_word) state_nxt = S_FILL;
            S_FILL:  if (last_word) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready       = 1'b0;
        done        = 1'b0;
        cache_word  = '0;
        cache_we    = 1'b0;
        cache_wdata = '0;
        mem_sel     = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        unique case (state)
            S_IDLE: ready = 1'b1;
            S_WBACK: begin
                mem_sel    = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = wb_base_r | word_off;
                cache_word = cnt;
                mem_wdata  = cache_rdata;
            end
            S_FILL: begin
                mem_sel     = 1'b1;
                mem_rd      = 1'b1;
                mem_addr    = fill_base_r | word_off;
                cache_word  = cnt;
                cache_we    = 1'b1;
                cache_wdata = mem_rdata;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_line_xfer_ctrl.sv
// tb_line_xfer_ctrl
//   Bench for line_xfer_ctrl. Surrounds the controller with a 256-word memory
//   and a one-line cache array, expands every accepted request into the list
//   of per-cycle port values it must produce, and compares all outputs on
//   every falling edge. Directed transfers pin the model with literal values,
//   then randomized transfers with busy requests and aborting resets follow.
module tb_line_xfer_ctrl;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int OB = 2;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          wb;
    logic [AW-1:0] wb_base;
    logic [AW-1:0] fill_base;
    logic          ready;
    logic          done;
    logic [OB-1:0] cache_word;
    logic [DW-1:0] cache_rdata;
    logic          cache_we;
    logic [DW-1:0] cache_wdata;
    logic          mem_sel;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    logic [DW-1:0] mem   [256];
    logic [DW-1:0] cache [LW];

    assign mem_rdata   = mem[mem_addr];
    assign cache_rdata = cache[cache_word];

    line_xfer_ctrl #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_BITS(OB)) dut (
        .clk(clk), .rst(rst), .req(req), .wb(wb),
        .wb_base(wb_base), .fill_base(fill_base),
        .ready(ready), .done(done),
        .cache_word(cache_word), .cache_rdata(cache_rdata),
        .cache_we(cache_we), .cache_wdata(cache_wdata),
        .mem_sel(mem_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic          ready;
        logic          done;
        logic          sel;
        logic          rd;
        logic          wr;
        logic          we;
        logic [AW-1:0] addr;
        logic [OB-1:0] word;
        logic [DW-1:0] mwd;
        logic [DW-1:0] cwd;
    } exp_t;

    exp_t q[$];

    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    bit  model_on = 1'b0;
    bit  prev_done = 1'b0;

    // Writes seen on the ports during a cycle, applied to the arrays at the edge.
    bit            p_mw = 1'b0;
    bit            p_cw = 1'b0;
    logic [AW-1:0] p_ma;
    logic [DW-1:0] p_md;
    logic [OB-1:0] p_co;
    logic [DW-1:0] p_cd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic exp_t mk(logic rdy, logic dn, logic sel, logic rd, logic wr, logic we,
                                logic [AW-1:0] a, logic [OB-1:0] w,
                                logic [DW-1:0] mwd, logic [DW-1:0] cwd);
        exp_t e;
        e.ready = rdy; e.done = dn; e.sel = sel; e.rd = rd; e.wr = wr; e.we = we;
        e.addr = a; e.word = w; e.mwd = mwd; e.cwd = cwd;
        return e;
    endfunction

    // Expands an accepted request into the exact sequence of cycles it must produce.
    task automatic push_xfer(input logic do_wb, input logic [AW-1:0] vb, input logic [AW-1:0] fb);
        logic [DW-1:0] shadow [256];
        logic [AW-1:0] vline;
        logic [AW-1:0] fline;
        logic [AW-1:0] a;
        shadow = mem;
        vline  = AW'((int'(vb) / LW) * LW);
        fline  = AW'((int'(fb) / LW) * LW);
        if (do_wb) begin
            for (int i = 0; i < LW; i++) begin
                a = AW'(int'(vline) + i);
                q.push_back(mk(0, 0, 1, 0, 1, 0, a, OB'(i), cache[i], '0));
                shadow[a] = cache[i];
            end
        end
        for (int i = 0; i < LW; i++) begin
            a = AW'(int'(fline) + i);
            q.push_back(mk(0, 0, 1, 1, 0, 1, a, OB'(i), '0, shadow[a]));
        end
        q.push_back(mk(0, 1, 0, 0, 0, 0, '0, '0, '0, '0));
    endtask

    task automatic model_step();
        if (rst) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (req) push_xfer(wb, wb_base, fill_base);
        end else begin
            void'(q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (p_mw) mem[p_ma] = p_md;
        if (p_cw) cache[p_co] = p_cd;
        p_mw = 1'b0;
        p_cw = 1'b0;
        model_step();
        cyc++;
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        p_mw = mem_sel && mem_wr;
        p_ma = mem_addr;
        p_md = mem_wdata;
        p_cw = cache_we;
        p_co = cache_word;
        p_cd = cache_wdata;
        if (model_on) begin
            e = mk(1, 0, 0, 0, 0, 0, '0, '0, '0, '0);
            if (q.size() > 0) e = q[0];
            chk("ready",       32'(ready),       32'(e.ready));
            chk("done",        32'(done),        32'(e.done));
            chk("mem_sel",     32'(mem_sel),     32'(e.sel));
            chk("mem_rd",      32'(mem_rd),      32'(e.rd));
            chk("mem_wr",      32'(mem_wr),      32'(e.wr));
            chk("cache_we",    32'(cache_we),    32'(e.we));
            chk("mem_addr",    32'(mem_addr),    32'(e.addr));
            chk("cache_word",  32'(cache_word),  32'(e.word));
            chk("mem_wdata",   32'(mem_wdata),   32'(e.mwd));
            chk("cache_wdata", 32'(cache_wdata), 32'(e.cwd));
            chk("rd_wr_excl",  32'(mem_rd && mem_wr), 32'(0));
            if (prev_done) chk("done_width", 32'(done), 32'(0));
            prev_done = done;
        end
    end

    // Runs from the request cycle until ready returns; optional busy request
    // and reset pokes at given cycle numbers relative to the request.
    task automatic xfer_wait(input int start, input int poke_req, input int poke_rst,
                             output int dc, output int dn, output int rc);
        dc = -1; dn = 0; rc = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            req       = (k == poke_req);
            rst       = (k == poke_rst);
            wb        = 1'($urandom);
            wb_base   = AW'($urandom);
            fill_base = AW'($urandom);
            #2;
            if (done) begin
                dn++;
                dc = cyc - start;
            end
            if (ready) begin
                rc = cyc - start;
                break;
            end
        end
        chk("ready_returned", 32'(rc >= 0), 32'(1));
    endtask

    int start, dc, dn, rc;

    initial begin
        rst = 1'b1; req = 1'b0; wb = 1'b0; wb_base = '0; fill_base = '0;
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < LW; i++) cache[i] = DW'($urandom);
        tick();
        model_on = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // fill-only, line 0x44
        for (int i = 0; i < LW; i++) mem[8'h44 + i] = DW'(16'h00A0 + i);
        req = 1'b1; wb = 1'b0; fill_base = 8'h47; wb_base = 8'h99; start = cyc;
        xfer_wait(start, 0, 0, dc, dn, rc);
        chk("t1_done_cyc", 32'(dc), 32'(5));
        chk("t1_done_cnt", 32'(dn), 32'(1));
        chk("t1_ready_cyc", 32'(rc), 32'(6));
        for (int i = 0; i < LW; i++) chk("t1_cache", 32'(cache[i]), 32'(16'h00A0 + i));

        // write-back + fill issued in the cycle ready returns
        for (int i = 0; i < LW; i++) begin
            cache[i] = DW'(16'h00B0 + i);
            mem[8'h20 + i] = DW'(16'h00C0 + i);
        end
        req = 1'b1; wb = 1'b1; wb_base = 8'h10; fill_base = 8'h20; start = cyc;
        xfer_wait(start, 0, 0, dc, dn, rc);
        chk("t2_done_cyc", 32'(dc), 32'(9));
        chk("t2_ready_cyc", 32'(rc), 32'(10));
        for (int i = 0; i < LW; i++) chk("t2_mem", 32'(mem[8'h10 + i]), 32'(16'h00B0 + i));
        for (int i = 0; i < LW; i++) chk("t2_cache", 32'(cache[i]), 32'(16'h00C0 + i));

        // busy request at cycle 2 is ignored
        for (int i = 0; i < LW; i++) mem[8'h54 + i] = DW'(16'h00D0 + i);
        req = 1'b1; wb = 1'b0; fill_base = 8'h55; start = cyc;
        xfer_wait(start, 2, 0, dc, dn, rc);
        chk("t3_done_cnt", 32'(dn), 32'(1));
        chk("t3_done_cyc", 32'(dc), 32'(5));
        chk("t3_ready_cyc", 32'(rc), 32'(6));
        tick();
        req = 1'b0;
        #2;
        chk("t3_no_restart", 32'(ready), 32'(1));

        // reset during write-back
        mem[8'h12] = 16'h1212;
        mem[8'h13] = 16'h1313;
        req = 1'b1; wb = 1'b1; wb_base = 8'h11; fill_base = 8'h30; start = cyc;
        xfer_wait(start, 0, 2, dc, dn, rc);
        chk("t4_ready_cyc", 32'(rc), 32'(3));
        chk("t4_mem_sel", 32'(mem_sel), 32'(0));
        chk("t4_no_done", 32'(dn), 32'(0));
        chk("t4_mem12", 32'(mem[8'h12]), 32'(16'h1212));
        chk("t4_mem13", 32'(mem[8'h13]), 32'(16'h1313));
        rst = 1'b0;

        // top-of-memory line
        for (int i = 0; i < LW; i++) mem[8'hFC + i] = DW'(16'h00F0 + i);
        req = 1'b1; wb = 1'b0; fill_base = 8'hFE; start = cyc;
        xfer_wait(start, 0, 0, dc, dn, rc);
        chk("t5_done_cyc", 32'(dc), 32'(5));
        for (int i = 0; i < LW; i++) chk("t5_cache", 32'(cache[i]), 32'(16'h00F0 + i));

        // randomized transfers
        for (int t = 0; t < 200; t++) begin
            int gap, pr, prs, dcy, exp_dn, exp_rc;
            logic wbv;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                req = 1'b0;
                tick();
                wb_base = AW'($urandom);
                fill_base = AW'($urandom);
            end
            for (int j = 0; j < 8; j++) mem[AW'($urandom)] = DW'($urandom);
            if ($urandom_range(0, 1) == 1)
                for (int j = 0; j < LW; j++) cache[j] = DW'($urandom);
            wbv = 1'($urandom);
            dcy = wbv ? 9 : 5;
            pr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, dcy)) : 0;
            prs = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, dcy)) : 0;
            req = 1'b1; wb = wbv; wb_base = AW'($urandom); fill_base = AW'($urandom);
            start = cyc;
            xfer_wait(start, pr, prs, dc, dn, rc);
            rst = 1'b0;
            req = 1'b0;
            exp_dn = (prs == 0 || prs >= dcy) ? 1 : 0;
            exp_rc = (prs != 0 && prs < dcy) ? prs + 1 : dcy + 1;
            chk("rnd_done_cnt", 32'(dn), 32'(exp_dn));
            chk("rnd_ready_cyc", 32'(rc), 32'(exp_rc));
        end

        req = 1'b0;
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
